// File: rtl/reg_delay_n.sv
// Programmable-latency data/valid delay line with hold, flush and occupancy count.
// Re-aligns one stream against another where a matched, runtime-selectable latency is needed.
module reg_delay_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 15,
    parameter int unsigned DLY_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_reg,
    input  logic             srdyi_reg,
    input  logic             i_hold,
    input  logic             i_flush,
    input  logic [DLY_W-1:0] i_dly,
    output logic [WIDTH-1:0] o_reg,
    output logic             srdyo_reg,
    output logic [DLY_W-1:0] o_dly,
    output logic [DLY_W-1:0] o_count
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r [DEPTH];
    logic [DEPTH-1:0] en;
    logic [DLY_W-1:0] dly_q;
    logic [DLY_W-1:0] count_q;
    logic [DLY_W-1:0] dly_clamp_c;
    logic [IDX_W-1:0] tap_c;
    logic             accept_c;
    logic             apply_c;

    // Requested delay limited to the physical range 1..DEPTH
    always_comb begin
        dly_clamp_c = i_dly;
        if (i_dly == '0) begin
            dly_clamp_c = DLY_W'(1);
        end else if (32'(i_dly) > DEPTH) begin
            dly_clamp_c = DLY_W'(DEPTH);
        end
    end

    assign tap_c     = IDX_W'(dly_q - DLY_W'(1));
    assign o_reg     = r[tap_c];
    assign srdyo_reg = en[tap_c] & ~i_hold;
    assign o_dly     = dly_q;
    assign o_count   = count_q;

    assign accept_c = srdyi_reg & ~i_hold & ~i_flush;
    // A tap change is only safe with nothing in flight, so no item sees a mixed latency
    assign apply_c  = (count_q == '0) && (dly_clamp_c != dly_q) && !accept_c && !i_flush;

    // Data shift chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r[i] <= '0;
            end
        end else if (!i_hold) begin
            r[0] <= i_reg;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r[i] <= r[i-1];
            end
        end
    end

    // Valid chain, occupancy and active delay
    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= '0;
            count_q <= '0;
            dly_q   <= DLY_W'(DEPTH);
        end else begin
            // Clearing on apply keeps valids already past the old tap from re-emitting
            if (i_flush || apply_c) begin
                en <= '0;
            end else if (!i_hold) begin
                en <= DEPTH'({en, accept_c});
            end

            if (i_flush) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + DLY_W'(accept_c) - DLY_W'(srdyo_reg);
            end

            if (apply_c) begin
                dly_q <= dly_clamp_c;
            end
        end
    end

endmodule

// File: tb/tb_reg_delay_n.sv
// Bench for reg_delay_n: directed table, hand-written corner sequences and a
// randomized run checked against an item-queue reference model.
module tb_reg_delay_n;
    logic        clk;
    logic        rst;
    logic [31:0] i_reg;
    logic        srdyi_reg;
    logic        i_hold;
    logic        i_flush;
    logic [3:0]  i_dly;
    logic [31:0] o_reg;
    logic        srdyo_reg;
    logic [3:0]  o_dly;
    logic [3:0]  o_count;

    logic [2:0]  d2_dly;
    logic [7:0]  d2_o_reg;
    logic        d2_srdyo;
    logic [2:0]  d2_o_dly;
    logic [2:0]  d2_o_count;

    reg_delay_n #(.WIDTH(32), .DEPTH(15)) dut (
        .clk(clk), .rst(rst), .i_reg(i_reg), .srdyi_reg(srdyi_reg),
        .i_hold(i_hold), .i_flush(i_flush), .i_dly(i_dly),
        .o_reg(o_reg), .srdyo_reg(srdyo_reg), .o_dly(o_dly), .o_count(o_count)
    );

    // Small instance where out-of-range delay requests are representable
    reg_delay_n #(.WIDTH(8), .DEPTH(5)) dut2 (
        .clk(clk), .rst(rst), .i_reg(8'h00), .srdyi_reg(1'b0),
        .i_hold(1'b0), .i_flush(1'b0), .i_dly(d2_dly),
        .o_reg(d2_o_reg), .srdyo_reg(d2_srdyo), .o_dly(d2_o_dly), .o_count(d2_o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          age;
    } item_t;

    typedef struct {
        logic        srdyi;
        logic [3:0]  dly;
        logic [31:0] data;
        logic [2:0]  d2;
        logic        exp_v;
        logic [31:0] exp_data;
        logic [3:0]  exp_cnt;
        logic [3:0]  exp_dly;
        logic [2:0]  exp_d2;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit checking = 0;

    item_t q[$];
    int    m_dly;

    logic        smp_v;
    logic [31:0] smp_data;
    logic [3:0]  smp_cnt;
    logic [3:0]  smp_dly;
    logic [2:0]  smp_d2;

    int first_acc, first_emit, last_emit, emit_n, max_cnt, hits, watch_acc, watch_emit;
    logic [31:0] watch;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int clamp(input int d);
        if (d == 0) return 1;
        if (d > 15) return 15;
        return d;
    endfunction

    task automatic mon_clear(input logic [31:0] w);
        first_acc = -1; first_emit = -1; last_emit = -1; emit_n = 0;
        max_cnt = 0; hits = 0; watch_acc = -1; watch_emit = -1; watch = w;
    endtask

    // Reference: in-flight items age on every unheld edge and leave when they reach the tap
    task automatic model_cycle(input logic r_, s_, h_, f_, input logic [3:0] d_, input logic [31:0] w_);
        logic  exp_v;
        logic  acc;
        logic  apply;
        item_t it;
        exp_v = !h_ && (q.size() > 0) && (q[0].age == m_dly - 1);
        chk("srdyo_reg", 32'(smp_v), 32'(exp_v));
        chk("o_count", 32'(smp_cnt), 32'(q.size()));
        chk("o_dly", 32'(smp_dly), 32'(m_dly));
        if (exp_v) chk("o_reg", smp_data, q[0].data);
        if (r_) begin
            q.delete();
            m_dly = 15;
        end else begin
            acc   = s_ && !h_ && !f_;
            apply = (q.size() == 0) && (clamp(int'(d_)) != m_dly) && !acc && !f_;
            if (f_) begin
                q.delete();
            end else begin
                if (exp_v) void'(q.pop_front());
                if (!h_) foreach (q[i]) q[i].age++;
                if (acc) begin
                    it.data = w_;
                    it.age  = 0;
                    q.push_back(it);
                end
            end
            if (apply) m_dly = clamp(int'(d_));
        end
    endtask

    task automatic step(input logic r_, s_, h_, f_, input logic [3:0] d_, input logic [31:0] w_);
        rst = r_; srdyi_reg = s_; i_hold = h_; i_flush = f_; i_dly = d_; i_reg = w_;
        @(negedge clk);
        smp_v = srdyo_reg; smp_data = o_reg; smp_cnt = o_count; smp_dly = o_dly; smp_d2 = d2_o_dly;
        if (checking) begin
            if (smp_v) begin
                emit_n++;
                if (first_emit < 0) first_emit = cyc;
                last_emit = cyc;
                if (smp_data == watch) begin hits++; watch_emit = cyc; end
            end
            if (s_ && !h_ && !f_ && !r_) begin
                if (first_acc < 0) first_acc = cyc;
                if (w_ == watch) watch_acc = cyc;
            end
            if (int'(smp_cnt) > max_cnt) max_cnt = int'(smp_cnt);
            model_cycle(r_, s_, h_, f_, d_, w_);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    vec_t tbl[10];

    initial begin
        bit          seen0;
        bit          busy;
        logic [3:0]  tgt;
        logic        rr, ss, hh, ff;

        // Runtime delay change from idle at delay 15, plus clamp on the DEPTH=5 instance
        tbl[0] = '{1'b0, 4'd3, 32'h0,        3'd2, 1'b0, 32'h0,        4'd0, 4'd15, 3'd5};
        tbl[1] = '{1'b1, 4'd3, 32'hA5A5A5A5, 3'd7, 1'b0, 32'h0,        4'd0, 4'd3,  3'd2};
        tbl[2] = '{1'b0, 4'd3, 32'h0,        3'd7, 1'b0, 32'h0,        4'd1, 4'd3,  3'd5};
        tbl[3] = '{1'b0, 4'd3, 32'h0,        3'd0, 1'b0, 32'h0,        4'd1, 4'd3,  3'd5};
        tbl[4] = '{1'b0, 4'd3, 32'h0,        3'd0, 1'b1, 32'hA5A5A5A5, 4'd1, 4'd3,  3'd1};
        tbl[5] = '{1'b0, 4'd3, 32'h0,        3'd0, 1'b0, 32'h0,        4'd0, 4'd3,  3'd1};
        tbl[6] = '{1'b0, 4'd0, 32'h0,        3'd0, 1'b0, 32'h0,        4'd0, 4'd3,  3'd1};
        tbl[7] = '{1'b0, 4'd0, 32'h0,        3'd0, 1'b0, 32'h0,        4'd0, 4'd1,  3'd1};
        tbl[8] = '{1'b0, 4'(31), 32'h0,      3'd0, 1'b0, 32'h0,        4'd0, 4'd1,  3'd1};
        tbl[9] = '{1'b0, 4'd15, 32'h0,       3'd0, 1'b0, 32'h0,        4'd0, 4'd15, 3'd1};

        rst = 1'b1; srdyi_reg = 1'b1; i_hold = 1'b0; i_flush = 1'b0;
        i_dly = 4'd15; i_reg = 32'h0; d2_dly = 3'd5;
        mon_clear(32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        cyc++;
        checking = 1;
        m_dly = 15;

        // Reset and legacy latency
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 32'hDEADBEEF);
        chk("reset_o_reg", smp_data, 32'h0);
        chk("reset_srdyo", 32'(smp_v), 32'h0);
        chk("reset_o_dly", 32'(smp_dly), 32'd15);
        chk("reset_count", 32'(smp_cnt), 32'h0);
        mon_clear(32'hFFFF_FFFF);
        for (int w = 1; w <= 32; w++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 32'(w));
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 32'h0);
        chk("legacy_latency", 32'(first_emit - first_acc), 32'd15);
        chk("legacy_emits", 32'(emit_n), 32'd32);
        chk("legacy_no_gaps", 32'(last_emit - first_emit), 32'd31);
        chk("legacy_max_count", 32'(max_cnt), 32'd15);

        // Table-driven delay change
        for (int i = 0; i < 10; i++) begin
            d2_dly = tbl[i].d2;
            step(1'b0, tbl[i].srdyi, 1'b0, 1'b0, tbl[i].dly, tbl[i].data);
            chk($sformatf("tbl%0d_srdyo", i), 32'(smp_v), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) chk($sformatf("tbl%0d_data", i), smp_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_count", i), 32'(smp_cnt), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_dly", i), 32'(smp_dly), 32'(tbl[i].exp_dly));
            chk($sformatf("tbl%0d_d2_dly", i), 32'(smp_d2), 32'(tbl[i].exp_d2));
        end

        // Blocked delay change with 4 items in flight
        mon_clear(32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h40 + 32'(i));
        seen0 = 0;
        for (int k = 0; k < 40 && !seen0; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 32'h0);
            if (smp_cnt != 4'd0) chk("blocked_dly_held", 32'(smp_dly), 32'd15);
            else seen0 = 1;
        end
        chk("blocked_drain", 32'(smp_cnt), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 32'h0);
        chk("blocked_apply", 32'(smp_dly), 32'd2);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 32'h0);
        chk("blocked_no_restale", 32'(emit_n), 32'd4);

        // Items past a short tap must not resurface after growing the delay
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h21);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h22);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 32'h0);

        // Hold mid-flight at delay 5
        mon_clear(32'h11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 32'h11);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 32'h0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 32'h99);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 32'h0);
        chk("hold_latency", 32'(watch_emit - watch_acc), 32'd8);
        chk("hold_once", 32'(hits), 32'd1);
        chk("hold_total_emits", 32'(emit_n), 32'd1);

        // Flush with 5 in flight while 0x77 is presented
        mon_clear(32'h77);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 32'h51 + 32'(i));
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 32'h77);
        chk("flush_cycle_emit", 32'(smp_v), 32'd1);
        chk("flush_cycle_data", smp_data, 32'h51);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 32'h0);
        chk("flush_count", 32'(smp_cnt), 32'd0);
        for (int k = 0; k < 14; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 32'h0);
        chk("flush_emits", 32'(emit_n), 32'd1);
        chk("flush_0x77_absent", 32'(hits), 32'd0);

        // Flush together with hold
        mon_clear(32'hEE);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 32'h61 + 32'(i));
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 32'hEE);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 32'h0);
        chk("flush_hold_count", 32'(smp_cnt), 32'd0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 32'h0);
        chk("flush_hold_emits", 32'(emit_n), 32'd0);

        // Reset together with flush, hold and valid
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 32'h71 + 32'(i));
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 32'hAB);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 32'h0);
        chk("rst_combo_count", 32'(smp_cnt), 32'd0);
        chk("rst_combo_dly", 32'(smp_dly), 32'd15);
        chk("rst_combo_srdyo", 32'(smp_v), 32'd0);
        chk("rst_combo_o_reg", smp_data, 32'h0);

        // Randomized run against the reference model
        busy = 1'b1;
        tgt  = 4'd15;
        for (int k = 0; k < 3000; k++) begin
            if (k % 80 == 0) busy = !busy;
            rr = ($urandom_range(0, 299) == 0);
            hh = ($urandom_range(0, 99) < 15);
            ff = ($urandom_range(0, 99) < 3);
            ss = ($urandom_range(0, 99) < (busy ? 80 : 8));
            if ($urandom_range(0, 39) == 0) tgt = 4'($urandom_range(0, 15));
            step(rr, ss, hh, ff, tgt, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
